// File: rtl/hazard_ctrl.sv
// Hazard and forwarding controller for the 5-stage MIPS pipeline: decodes IR_D,
// tracks E/M/W tags, and drives stall, forward-mux selects and the mult/div busy counter.
module hazard_ctrl #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] IR_D,
   output logic        stall,
   output logic [2:0]  Forward_RS_D,
   output logic [2:0]  Forward_RT_D,
   output logic [1:0]  Forward_RS_E,
   output logic [1:0]  Forward_RT_E,
   output logic        Forward_RT_M,
   output logic        md_start,
   output logic        md_busy
);

   localparam int MD_MAX = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
   localparam int CW     = $clog2(MD_MAX + 1);
   localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES);
   localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES);

   localparam logic [5:0] OP_SPECIAL = 6'h00;
   localparam logic [5:0] OP_JAL     = 6'h03;
   localparam logic [5:0] OP_BEQ     = 6'h04;
   localparam logic [5:0] OP_ORI     = 6'h0d;
   localparam logic [5:0] OP_LUI     = 6'h0f;
   localparam logic [5:0] OP_LW      = 6'h23;
   localparam logic [5:0] OP_SW      = 6'h2b;

   localparam logic [5:0] FN_JR   = 6'h08;
   localparam logic [5:0] FN_MFHI = 6'h10;
   localparam logic [5:0] FN_MTHI = 6'h11;
   localparam logic [5:0] FN_MFLO = 6'h12;
   localparam logic [5:0] FN_MTLO = 6'h13;
   localparam logic [5:0] FN_MULT = 6'h18;
   localparam logic [5:0] FN_DIV  = 6'h1a;
   localparam logic [5:0] FN_ADDU = 6'h21;
   localparam logic [5:0] FN_SUBU = 6'h23;

   typedef enum logic [1:0] {
      CLS_ALU  = 2'd0,
      CLS_LOAD = 2'd1,
      CLS_LINK = 2'd2
   } cls_e;

   // Source fields are kept only when the instruction really reads them, so
   // immediate/target bits never look like register dependencies.
   typedef struct packed {
      logic [4:0] rs;
      logic [4:0] rt;
      logic [4:0] dest;
      cls_e       cls;
      logic [1:0] tnew;
      logic       md_op;
      logic       md_div;
   } tag_t;

   logic [5:0] opcode;
   logic [5:0] funct;
   logic [4:0] ir_rs;
   logic [4:0] ir_rt;
   logic [4:0] ir_rd;
   logic       unused_shamt;

   assign opcode       = IR_D[31:26];
   assign funct        = IR_D[5:0];
   assign ir_rs        = IR_D[25:21];
   assign ir_rt        = IR_D[20:16];
   assign ir_rd        = IR_D[15:11];
   assign unused_shamt = ^IR_D[10:6];

   tag_t       d_tag;
   logic       use_rs;
   logic       use_rt;
   logic [1:0] tuse_rs;
   logic [1:0] tuse_rt;
   logic       d_mdclass;

   tag_t       e_q;
   logic [4:0] m_rt;
   logic [4:0] m_dest;
   cls_e       m_cls;
   logic [1:0] m_tnew;
   logic [4:0] w_dest;
   cls_e       w_cls;
   logic [CW-1:0] md_cnt;

   always_comb begin
      d_tag     = '0;
      use_rs    = 1'b0;
      use_rt    = 1'b0;
      tuse_rs   = 2'd0;
      tuse_rt   = 2'd0;
      d_mdclass = 1'b0;
      case (opcode)
         OP_SPECIAL: begin
            case (funct)
               FN_ADDU, FN_SUBU: begin
                  d_tag.dest = ir_rd;
                  d_tag.tnew = 2'd1;
                  use_rs     = 1'b1;
                  use_rt     = 1'b1;
                  tuse_rs    = 2'd1;
                  tuse_rt    = 2'd1;
               end
               FN_JR: begin
                  use_rs  = 1'b1;
                  tuse_rs = 2'd0;
               end
               FN_MULT, FN_DIV: begin
                  use_rs       = 1'b1;
                  use_rt       = 1'b1;
                  tuse_rs      = 2'd1;
                  tuse_rt      = 2'd1;
                  d_tag.md_op  = 1'b1;
                  d_tag.md_div = (funct == FN_DIV);
                  d_mdclass    = 1'b1;
               end
               FN_MFHI, FN_MFLO: begin
                  d_tag.dest = ir_rd;
                  d_tag.tnew = 2'd1;
                  d_mdclass  = 1'b1;
               end
               FN_MTHI, FN_MTLO: begin
                  use_rs    = 1'b1;
                  tuse_rs   = 2'd1;
                  d_mdclass = 1'b1;
               end
               default: ;
            endcase
         end
         OP_ORI: begin
            d_tag.dest = ir_rt;
            d_tag.tnew = 2'd1;
            use_rs     = 1'b1;
            tuse_rs    = 2'd1;
         end
         OP_LUI: begin
            d_tag.dest = ir_rt;
            d_tag.tnew = 2'd1;
         end
         OP_LW: begin
            d_tag.dest = ir_rt;
            d_tag.cls  = CLS_LOAD;
            d_tag.tnew = 2'd2;
            use_rs     = 1'b1;
            tuse_rs    = 2'd1;
         end
         OP_SW: begin
            use_rs  = 1'b1;
            use_rt  = 1'b1;
            tuse_rs = 2'd1;
            tuse_rt = 2'd2;
         end
         OP_BEQ: begin
            use_rs  = 1'b1;
            use_rt  = 1'b1;
            tuse_rs = 2'd0;
            tuse_rt = 2'd0;
         end
         OP_JAL: begin
            d_tag.dest = 5'd31;
            d_tag.cls  = CLS_LINK;
            d_tag.tnew = 2'd1;
         end
         default: ;
      endcase
      d_tag.rs = use_rs ? ir_rs : 5'd0;
      d_tag.rt = use_rt ? ir_rt : 5'd0;
   end

   function automatic logic src_hazard(input logic [4:0] r, input logic [1:0] tuse,
                                       input logic [4:0] e_dest, input logic [1:0] e_tnew,
                                       input logic [4:0] mm_dest, input logic [1:0] mm_tnew);
      return (r != 5'd0) &&
             (((e_dest == r) && (e_tnew > tuse)) || ((mm_dest == r) && (mm_tnew > tuse)));
   endfunction

   function automatic logic [2:0] fwd_id(input logic [4:0] r,
                                         input logic [4:0] mm_dest, input cls_e mm_cls,
                                         input logic [1:0] mm_tnew,
                                         input logic [4:0] ww_dest, input cls_e ww_cls);
      if (r == 5'd0)
         return 3'd0;
      else if ((mm_dest == r) && (mm_tnew == 2'd0))
         return (mm_cls == CLS_LINK) ? 3'd3 : 3'd1;
      else if (ww_dest == r)
         return (ww_cls == CLS_LINK) ? 3'd4 : 3'd2;
      else
         return 3'd0;
   endfunction

   function automatic logic [1:0] fwd_ex(input logic [4:0] r,
                                         input logic [4:0] mm_dest, input cls_e mm_cls,
                                         input logic [1:0] mm_tnew, input logic [4:0] ww_dest);
      if (r == 5'd0)
         return 2'd0;
      else if ((mm_dest == r) && (mm_tnew == 2'd0))
         return (mm_cls == CLS_LINK) ? 2'd3 : 2'd1;
      else if (ww_dest == r)
         return 2'd2;
      else
         return 2'd0;
   endfunction

   logic haz_rs;
   logic haz_rt;

   assign haz_rs = src_hazard(d_tag.rs, tuse_rs, e_q.dest, e_q.tnew, m_dest, m_tnew);
   assign haz_rt = src_hazard(d_tag.rt, tuse_rt, e_q.dest, e_q.tnew, m_dest, m_tnew);

   assign md_start = e_q.md_op;
   assign md_busy  = (md_cnt != '0);
   assign stall    = ~reset & (haz_rs | haz_rt | (d_mdclass & (md_busy | md_start)));

   assign Forward_RS_D = fwd_id(d_tag.rs, m_dest, m_cls, m_tnew, w_dest, w_cls);
   assign Forward_RT_D = fwd_id(d_tag.rt, m_dest, m_cls, m_tnew, w_dest, w_cls);
   assign Forward_RS_E = fwd_ex(e_q.rs, m_dest, m_cls, m_tnew, w_dest);
   assign Forward_RT_E = fwd_ex(e_q.rt, m_dest, m_cls, m_tnew, w_dest);
   assign Forward_RT_M = (m_rt != 5'd0) && (w_dest == m_rt);

   // Tags advance in lockstep with the datapath; a stall turns the ID/EX slot
   // into a bubble, and the busy counter loads on the edge after mult/div sits in E.
   always_ff @(posedge clk) begin
      if (reset) begin
         e_q    <= '0;
         m_rt   <= 5'd0;
         m_dest <= 5'd0;
         m_cls  <= CLS_ALU;
         m_tnew <= 2'd0;
         w_dest <= 5'd0;
         w_cls  <= CLS_ALU;
         md_cnt <= '0;
      end else begin
         w_dest <= m_dest;
         w_cls  <= m_cls;
         m_rt   <= e_q.rt;
         m_dest <= e_q.dest;
         m_cls  <= e_q.cls;
         m_tnew <= (e_q.tnew == 2'd0) ? 2'd0 : e_q.tnew - 2'd1;
         e_q    <= stall ? '0 : d_tag;
         if (e_q.md_op)
            md_cnt <= e_q.md_div ? DIV_LOAD : MULT_LOAD;
         else if (md_cnt != '0)
            md_cnt <= md_cnt - CW'(1);
      end
   end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed vector table, mult/div corner
// sequences, and random instruction streams against an age-based pipeline model.
module tb_hazard_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] IR_D;
   logic        stall;
   logic [2:0]  Forward_RS_D;
   logic [2:0]  Forward_RT_D;
   logic [1:0]  Forward_RS_E;
   logic [1:0]  Forward_RT_E;
   logic        Forward_RT_M;
   logic        md_start;
   logic        md_busy;

   always #5 clk = ~clk;

   hazard_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk          (clk),
      .reset        (reset),
      .IR_D         (IR_D),
      .stall        (stall),
      .Forward_RS_D (Forward_RS_D),
      .Forward_RT_D (Forward_RT_D),
      .Forward_RS_E (Forward_RS_E),
      .Forward_RT_E (Forward_RT_E),
      .Forward_RT_M (Forward_RT_M),
      .md_start     (md_start),
      .md_busy      (md_busy)
   );

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic [31:0] ir;
      bit          rst;
      int stall, frsd, frtd, frse, frte, frtm, mds, mdb;
   } vec_t;

   typedef struct {
      int dest, rs, rt, cls, tnew, tuse_rs, tuse_rt, md_len;
      bit md_op, md_cls;
   } minfo_t;

   localparam int CLS_ALU = 0, CLS_LOAD = 1, CLS_LINK = 2;

   function automatic logic [31:0] r_ins(logic [5:0] fn, logic [4:0] rs, logic [4:0] rt, logic [4:0] rd);
      return {6'h00, rs, rt, rd, 5'd0, fn};
   endfunction

   function automatic logic [31:0] i_ins(logic [5:0] op, logic [4:0] rs, logic [4:0] rt, logic [15:0] imm);
      return {op, rs, rt, imm};
   endfunction

   function automatic logic [31:0] j_ins(logic [5:0] op, logic [25:0] target);
      return {op, target};
   endfunction

   // Instruction semantics straight from the ISA table: destination, class,
   // production latency and per-source use time (-1 = register not read).
   function automatic minfo_t decode(logic [31:0] ir);
      minfo_t d;
      int rs_f, rt_f, rd_f;
      d = '{default: 0};
      d.tuse_rs = -1;
      d.tuse_rt = -1;
      rs_f = int'(ir[25:21]);
      rt_f = int'(ir[20:16]);
      rd_f = int'(ir[15:11]);
      if (ir[31:26] == 6'h00) begin
         case (ir[5:0])
            6'h21, 6'h23: begin d.dest = rd_f; d.tnew = 1; d.tuse_rs = 1; d.tuse_rt = 1; end
            6'h08: d.tuse_rs = 0;
            6'h18: begin d.tuse_rs = 1; d.tuse_rt = 1; d.md_op = 1; d.md_cls = 1; d.md_len = 5; end
            6'h1a: begin d.tuse_rs = 1; d.tuse_rt = 1; d.md_op = 1; d.md_cls = 1; d.md_len = 10; end
            6'h10, 6'h12: begin d.dest = rd_f; d.tnew = 1; d.md_cls = 1; end
            6'h11, 6'h13: begin d.tuse_rs = 1; d.md_cls = 1; end
            default: ;
         endcase
      end else begin
         case (ir[31:26])
            6'h0d: begin d.dest = rt_f; d.tnew = 1; d.tuse_rs = 1; end
            6'h0f: begin d.dest = rt_f; d.tnew = 1; end
            6'h23: begin d.dest = rt_f; d.tnew = 2; d.cls = CLS_LOAD; d.tuse_rs = 1; end
            6'h2b: begin d.tuse_rs = 1; d.tuse_rt = 2; end
            6'h04: begin d.tuse_rs = 0; d.tuse_rt = 0; end
            6'h03: begin d.dest = 31; d.tnew = 1; d.cls = CLS_LINK; end
            default: ;
         endcase
      end
      d.rs = (d.tuse_rs >= 0) ? rs_f : 0;
      d.rt = (d.tuse_rt >= 0) ? rt_f : 0;
      return d;
   endfunction

   // Model: hist[c & 7] is the instruction that occupied E during cycle c, so
   // during cycle n the instruction issued at cycle n-a is 'a' stages past E and
   // its remaining latency is simply max(Tnew_E - a, 0).
   minfo_t hist [8];
   int     ncyc      = 0;
   int     md_enter  = -100;
   int     md_len    = 0;

   function automatic minfo_t at(int age);
      return hist[(ncyc - age) & 7];
   endfunction

   function automatic int tnew_at(minfo_t p, int age);
      return (p.tnew > age) ? p.tnew - age : 0;
   endfunction

   function automatic bit model_busy();
      return (ncyc - md_enter >= 1) && (ncyc - md_enter <= md_len);
   endfunction

   function automatic int fwd_d_model(int r);
      minfo_t m, w;
      m = at(1);
      w = at(2);
      if (r == 0) return 0;
      if (m.dest == r && tnew_at(m, 1) == 0) return (m.cls == CLS_LINK) ? 3 : 1;
      if (w.dest == r) return (w.cls == CLS_LINK) ? 4 : 2;
      return 0;
   endfunction

   function automatic int fwd_e_model(int r);
      minfo_t m, w;
      m = at(1);
      w = at(2);
      if (r == 0) return 0;
      if (m.dest == r && tnew_at(m, 1) == 0) return (m.cls == CLS_LINK) ? 3 : 1;
      if (w.dest == r) return 2;
      return 0;
   endfunction

   function automatic vec_t model_expect(logic [31:0] ir, bit rst);
      vec_t   v;
      minfo_t id, p;
      bit     s;
      id = decode(ir);
      s  = 0;
      for (int a = 0; a < 2; a++) begin
         p = at(a);
         if (id.rs != 0 && p.dest == id.rs && tnew_at(p, a) > id.tuse_rs) s = 1;
         if (id.rt != 0 && p.dest == id.rt && tnew_at(p, a) > id.tuse_rt) s = 1;
      end
      if (id.md_cls && (model_busy() || at(0).md_op)) s = 1;
      v.ir    = ir;
      v.rst   = rst;
      v.stall = (rst || !s) ? 0 : 1;
      v.frsd  = fwd_d_model(id.rs);
      v.frtd  = fwd_d_model(id.rt);
      v.frse  = fwd_e_model(at(0).rs);
      v.frte  = fwd_e_model(at(0).rt);
      v.frtm  = (at(1).rt != 0 && at(2).dest == at(1).rt) ? 1 : 0;
      v.mds   = at(0).md_op ? 1 : 0;
      v.mdb   = model_busy() ? 1 : 0;
      return v;
   endfunction

   task automatic model_advance(logic [31:0] ir, bit rst, int s);
      if (rst) begin
         for (int i = 0; i < 8; i++) hist[i] = decode(32'd0);
         md_len   = 0;
         md_enter = -100;
      end else begin
         if (at(0).md_op) begin
            md_enter = ncyc;
            md_len   = at(0).md_len;
         end
         hist[(ncyc + 1) & 7] = (s != 0) ? decode(32'd0) : decode(ir);
      end
      ncyc++;
   endtask

   // Drive one ID instruction for a cycle, sample mid-cycle, then step the model.
   task automatic apply_stimulus(input logic [31:0] ir, input bit rst, output vec_t act, output vec_t mdl);
      IR_D  = ir;
      reset = rst;
      #4;
      act.ir    = ir;
      act.rst   = rst;
      act.stall = int'(stall);
      act.frsd  = int'(Forward_RS_D);
      act.frtd  = int'(Forward_RT_D);
      act.frse  = int'(Forward_RS_E);
      act.frte  = int'(Forward_RT_E);
      act.frtm  = int'(Forward_RT_M);
      act.mds   = int'(md_start);
      act.mdb   = int'(md_busy);
      mdl = model_expect(ir, rst);
      @(posedge clk);
      model_advance(ir, rst, mdl.stall);
      #1;
   endtask

   task automatic check_output(string name, int actual, int expected);
      n_checks++;
      if (actual !== expected) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   task automatic check_vec(string tag, vec_t act, vec_t exp);
      check_output({tag, ".stall"}, act.stall, exp.stall);
      check_output({tag, ".Forward_RS_D"}, act.frsd, exp.frsd);
      check_output({tag, ".Forward_RT_D"}, act.frtd, exp.frtd);
      check_output({tag, ".Forward_RS_E"}, act.frse, exp.frse);
      check_output({tag, ".Forward_RT_E"}, act.frte, exp.frte);
      check_output({tag, ".Forward_RT_M"}, act.frtm, exp.frtm);
      check_output({tag, ".md_start"}, act.mds, exp.mds);
      check_output({tag, ".md_busy"}, act.mdb, exp.mdb);
   endtask

   function automatic vec_t mk(logic [31:0] ir, bit rst, int s, int rsd, int rtd,
                               int rse, int rte, int rtm, int mds, int mdb);
      vec_t v;
      v.ir = ir; v.rst = rst; v.stall = s; v.frsd = rsd; v.frtd = rtd;
      v.frse = rse; v.frte = rte; v.frtm = rtm; v.mds = mds; v.mdb = mdb;
      return v;
   endfunction

   // Hold a HI/LO reader behind a mult/div until it issues and tally the cycles.
   task automatic md_sequence(string tag, logic [31:0] md_ir, logic [31:0] rd_ir,
                              int exp_starts, int exp_busy, int exp_stalls);
      vec_t act, mdl;
      int starts = 0, busy = 0, stalls = 0;
      bit issued = 0;
      apply_stimulus(md_ir, 0, act, mdl);
      for (int i = 0; i < 40 && !issued; i++) begin
         apply_stimulus(rd_ir, 0, act, mdl);
         starts += act.mds;
         busy   += act.mdb;
         stalls += act.stall;
         if (act.stall == 0) issued = 1;
      end
      check_output({tag, ".issued"}, int'(issued), 1);
      check_output({tag, ".md_start_cycles"}, starts, exp_starts);
      check_output({tag, ".md_busy_cycles"}, busy, exp_busy);
      check_output({tag, ".stall_cycles"}, stalls, exp_stalls);
      apply_stimulus(32'd0, 0, act, mdl);
      apply_stimulus(32'd0, 0, act, mdl);
   endtask

   function automatic logic [31:0] rand_ins();
      logic [4:0]  a, b, c;
      logic [15:0] imm;
      a   = 5'($urandom_range(0, 7));
      b   = 5'($urandom_range(0, 7));
      c   = 5'($urandom_range(0, 7));
      imm = 16'($urandom);
      if ($urandom_range(0, 9) == 0) c = 5'd31;
      case ($urandom_range(0, 17))
         0:  return r_ins(6'h21, a, b, c);
         1:  return r_ins(6'h23, a, b, c);
         2:  return i_ins(6'h0d, a, b, imm);
         3:  return i_ins(6'h0f, a, b, imm);
         4:  return i_ins(6'h23, a, b, imm);
         5:  return i_ins(6'h2b, a, b, imm);
         6:  return i_ins(6'h04, a, b, imm);
         7:  return j_ins(6'h02, 26'($urandom));
         8:  return j_ins(6'h03, 26'($urandom));
         9:  return r_ins(6'h08, c, 5'd0, 5'd0);
         10: return r_ins(6'h18, a, b, 5'd0);
         11: return r_ins(6'h1a, a, b, 5'd0);
         12: return r_ins(6'h10, 5'd0, 5'd0, c);
         13: return r_ins(6'h12, 5'd0, 5'd0, c);
         14: return r_ins(6'h11, a, 5'd0, 5'd0);
         15: return r_ins(6'h13, a, 5'd0, 5'd0);
         16: return 32'd0;
         default: return $urandom;
      endcase
   endfunction

   initial begin
      vec_t tbl[$];
      vec_t act, mdl;
      logic [31:0] NOP, ADDU123, BEQ10, LW4, ADDU544, BEQ44, JAL, JR31;
      logic [31:0] ADDU011, BEQ00, ADDU623, SW6, DIV, MULT, MFLO, MFHI;
      logic [31:0] ir;
      bit          rst;

      NOP     = 32'd0;
      ADDU123 = r_ins(6'h21, 5'd2, 5'd3, 5'd1);
      BEQ10   = i_ins(6'h04, 5'd1, 5'd0, 16'h0004);
      LW4     = i_ins(6'h23, 5'd0, 5'd4, 16'h0000);
      ADDU544 = r_ins(6'h21, 5'd4, 5'd4, 5'd5);
      BEQ44   = i_ins(6'h04, 5'd4, 5'd4, 16'h0002);
      JAL     = j_ins(6'h03, 26'h0000040);
      JR31    = r_ins(6'h08, 5'd31, 5'd0, 5'd0);
      ADDU011 = r_ins(6'h21, 5'd1, 5'd1, 5'd0);
      BEQ00   = i_ins(6'h04, 5'd0, 5'd0, 16'h0001);
      ADDU623 = r_ins(6'h21, 5'd2, 5'd3, 5'd6);
      SW6     = i_ins(6'h2b, 5'd0, 5'd6, 16'h0008);
      DIV     = r_ins(6'h1a, 5'd2, 5'd3, 5'd0);
      MULT    = r_ins(6'h18, 5'd2, 5'd3, 5'd0);
      MFLO    = r_ins(6'h12, 5'd0, 5'd0, 5'd7);
      MFHI    = r_ins(6'h10, 5'd0, 5'd0, 5'd8);

      //            ir       rst st rsD rtD rsE rtE rtM mds mdb
      tbl.push_back(mk(NOP,     1, 0, 0, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(ADDU123, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(BEQ10,   0, 1, 0, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(BEQ10,   0, 0, 1, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(NOP,     0, 0, 0, 0, 2, 0, 0, 0, 0));
      tbl.push_back(mk(NOP,     0, 0, 0, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(LW4,     0, 0, 0, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(ADDU544, 0, 1, 0, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(ADDU544, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(NOP,     0, 0, 0, 0, 2, 2, 0, 0, 0));
      tbl.push_back(mk(NOP,     0, 0, 0, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(LW4,     0, 0, 0, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(BEQ44,   0, 1, 0, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(BEQ44,   0, 1, 0, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(BEQ44,   0, 0, 2, 2, 0, 0, 0, 0, 0));
      tbl.push_back(mk(NOP,     0, 0, 0, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(JAL,     0, 0, 0, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(JR31,    0, 1, 0, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(JR31,    0, 0, 3, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(NOP,     0, 0, 0, 0, 2, 0, 0, 0, 0));
      tbl.push_back(mk(JAL,     0, 0, 0, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(NOP,     0, 0, 0, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(NOP,     0, 0, 0, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(JR31,    0, 0, 4, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(NOP,     0, 0, 0, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(ADDU011, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(BEQ00,   0, 0, 0, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(NOP,     0, 0, 0, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(ADDU623, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(SW6,     0, 0, 0, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(NOP,     0, 0, 0, 0, 0, 1, 0, 0, 0));
      tbl.push_back(mk(NOP,     0, 0, 0, 0, 0, 0, 1, 0, 0));
      tbl.push_back(mk(NOP,     0, 0, 0, 0, 0, 0, 0, 0, 0));

      for (int i = 0; i < 8; i++) hist[i] = decode(32'd0);
      reset = 1'b1;
      IR_D  = 32'd0;
      @(posedge clk);
      #1;

      for (int i = 0; i < tbl.size(); i++) begin
         apply_stimulus(tbl[i].ir, tbl[i].rst, act, mdl);
         check_vec($sformatf("vec%0d", i), act, tbl[i]);
      end

      md_sequence("div_mflo", DIV, MFLO, 1, 10, 11);
      md_sequence("mult_mfhi", MULT, MFHI, 1, 5, 6);

      // Reset in the middle of a divide must drop the busy count immediately.
      apply_stimulus(DIV, 0, act, mdl);
      apply_stimulus(NOP, 0, act, mdl);
      apply_stimulus(NOP, 0, act, mdl);
      apply_stimulus(MFLO, 0, act, mdl);
      check_output("div_busy.stall", act.stall, 1);
      check_output("div_busy.md_busy", act.mdb, 1);
      apply_stimulus(MFLO, 1, act, mdl);
      check_output("div_reset.stall", act.stall, 0);
      apply_stimulus(MFLO, 0, act, mdl);
      check_vec("after_reset", act, mk(MFLO, 0, 0, 0, 0, 0, 0, 0, 0, 0));

      apply_stimulus(NOP, 1, act, mdl);
      for (int i = 0; i < 3000; i++) begin
         ir  = rand_ins();
         rst = ($urandom_range(0, 99) == 0);
         apply_stimulus(ir, rst, act, mdl);
         check_vec($sformatf("rand%0d", i), act, mdl);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Central hazard and forwarding controller for the 5-stage MIPS pipeline.
- Decodes the instruction entering ID (IR_D) and tracks a tag pipeline for E/M/W in lockstep with the datapath pipeline registers.
- Generates the stall signal and all forward-mux selects, including Forward_RS_D/Forward_RT_D for the ID-stage forward muxes.
- Sequences the multi-cycle mult/div unit with a busy counter and stalls HI/LO-class instructions while it runs.

Parameters:
- MULT_CYCLES, 5, busy cycles after a mult enters E.
- DIV_CYCLES, 10, busy cycles after a div enters E.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- IR_D  input  32  instruction in ID.
- stall  output  1  1 = hold PC and IF/ID; insert bubble into ID/EX.
- Forward_RS_D  output  3  ID rs mux: 0 GRF, 1 ALUOUT_M, 2 Wdata, 3 PC8_M, 4 PC8_W.
- Forward_RT_D  output  3  ID rt mux, same encoding.
- Forward_RS_E  output  2  E rs mux: 0 pipe reg, 1 ALUOUT_M, 2 Wdata, 3 PC8_M.
- Forward_RT_E  output  2  E rt mux, same encoding.
- Forward_RT_M  output  1  M store-data mux: 0 pipe reg, 1 Wdata.
- md_start  output  1  high during the cycle a mult/div is in E.
- md_busy  output  1  busy counter != 0.

Behaviour:
- One clock domain. Reset is synchronous, active-high.
- Supported set: addu, subu, ori, lui, lw, sw, beq, j, jal, jr, mult, div, mfhi, mflo, mthi, mtlo, nop. Unknown opcodes decode as nop.
- Decode per instruction:
  - dest: rd for addu/subu/mfhi/mflo; rt for ori/lui/lw; 31 for jal; else 0.
  - class: ALU, LOAD or LINK.
  - Tnew_E: ALU 1, LOAD 2, LINK 1.
  - Tuse_rs: beq/jr 0; addu/subu/ori/lw/sw/mult/div/mthi/mtlo 1; else none.
  - Tuse_rt: beq 0; addu/subu/mult/div 1; sw 2; else none.
- Tag pipeline. Registers E, M, W each hold {rs, rt, dest, class, tnew}.
  - Each cycle: W<=M, M<=E with tnew=max(tnew-1,0), E<=decode(IR_D).
  - When stall=1, E<=bubble (dest 0, rs 0, rt 0). W tnew is treated as 0.
- Stall: assert combinationally when any of the following holds.
  - An ID source reg r != 0 with Tuse t matches the dest of stage E or M with that stage's tnew > t.
  - An md-class instruction (mult, div, mfhi, mflo, mthi, mtlo) is in ID and (md_busy=1 or md_start=1).
  - stall is forced 0 while reset=1.
- ID forwarding, per source r:
  - r==0 -> 0.
  - Else if M.dest==r and M.tnew==0 -> 1 (ALU) or 3 (LINK).
  - Else if W.dest==r -> 4 (LINK) or 2 (other).
  - Else -> 0.
  - M has priority over W.
- E forwarding, on E.rs/E.rt:
  - M match with tnew 0 -> 1/3.
  - Else W match -> 2.
  - Else 0.
- Forward_RT_M: 1 iff M.rt != 0 and W.dest==M.rt.
- MD counter:
  - When a mult/div enters E (E loaded from non-stalled ID), it loads MULT_CYCLES/DIV_CYCLES on the next edge.
  - Otherwise it decrements to 0 and saturates.
  - md_start = E holds mult/div.
- Reset: all tags become bubbles and the counter becomes 0.
  - Next cycle all outputs are 0: stall=0, all forward selects 0, md_start=0, md_busy=0.
  - Reset mid-mult/div aborts the count.
- Writes to $0 never produce a match.

Test Plan:
- addu $1,$2,$3 then beq $1,$0 -> stall=1 for 1 cycle; then Forward_RS_D=1; beq resolves with the ALUOUT_M value.
- lw $4,0($0) then addu $5,$4,$4 -> stall=1 for 1 cycle; then addu in E gets Forward_RS_E=2 and Forward_RT_E=2.
- lw $4 then beq $4,$4 -> stall=1 for 2 cycles; then Forward_RS_D=Forward_RT_D=2.
- jal then jr $31 -> stall=1 for 1 cycle; then Forward_RS_D=3. Separately, jal, nop, nop, jr $31 with jal at W -> Forward_RS_D=4, no stall.
- div then mflo -> md_start=1 for 1 cycle; md_busy=1 for exactly 10 cycles; mflo stalled 11 cycles total; then issued. mult then mfhi -> 6 stall cycles.
- addu $0,$1,$1 then beq $0,$0 -> no stall, all selects 0. Also assert reset during div busy -> md_busy=0 and stall=0 the following cycle.
